nonce_sweep_ctrl: RTL and testbench

NONCE_SWEEP_CTRL -- requirements
Module: nonce_sweep_ctrl

---
 rtl/nonce_sweep_ctrl_pkg.sv | 39 +++
 rtl/nonce_sweep_ctrl_if.sv | 23 ++
 rtl/sweep_watchdog.sv | 32 +++
 rtl/nonce_sweep_ctrl.sv | 102 ++++++++++
 tb/tb_nonce_sweep_ctrl.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nonce_sweep_ctrl_pkg.sv
// Shared miner constants for the nonce sweep controller: FSM encoding,
// watchdog defaults and the registered control word that goes with each state.
package nonce_sweep_ctrl_pkg;

    localparam int unsigned WATCHDOG_CYCLES_DEFAULT = 4096;
    localparam int unsigned WD_W_DEFAULT            = 13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        FOUND   = 3'd3,
        EXHAUST = 3'd4,
        TMO     = 3'd5
    } sweep_state_e;

    // State plus every output flag, so one assignment moves all of them together.
    typedef struct packed {
        sweep_state_e state;
        logic         hash_start;
        logic         busy;
        logic         found;
        logic         exhausted;
        logic         timeout;
    } ctrl_t;

    function automatic ctrl_t enter(sweep_state_e s);
        ctrl_t c;
        c            = '0;
        c.state      = s;
        c.hash_start = (s == ISSUE);
        c.busy       = (s == ISSUE) || (s == WAIT);
        c.found      = (s == FOUND);
        c.exhausted  = (s == EXHAUST);
        c.timeout    = (s == TMO);
        return c;
    endfunction

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Handshake between the sweep controller (master) and the hash core (slave).
interface nonce_sweep_ctrl_if;

    logic        hash_start;
    logic [31:0] hash_nonce;
    logic        hash_done;
    logic        hash_hit;

    modport master (
        output hash_start,
        output hash_nonce,
        input  hash_done,
        input  hash_hit
    );

    modport slave (
        input  hash_start,
        input  hash_nonce,
        output hash_done,
        output hash_hit
    );

endinterface

// File: rtl/sweep_watchdog.sv
// Per-nonce watchdog: counts enabled cycles since the last clear and flags the
// final allowed cycle so the controller can give up on a silent hash core.
module sweep_watchdog
    import nonce_sweep_ctrl_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEFAULT,
    parameter int unsigned WD_W            = WD_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WD_W-1:0] LAST = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] count;

    // NOTE: reset is synchronous, so it lives inside the clocked block and is
    // simply the highest-priority branch rather than part of the sensitivity list.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Walks an inclusive, wrap-capable nonce range through an external hash core,
// one nonce at a time, stopping on a hit, on range end, or on a watchdog expiry.
module nonce_sweep_ctrl
    import nonce_sweep_ctrl_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEFAULT,
    parameter int unsigned WD_W            = WD_W_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                ack,
    input  logic [31:0]         nonce_base,
    input  logic [31:0]         nonce_end,
    nonce_sweep_ctrl_if.master  hash,
    output logic                busy,
    output logic                found,
    output logic [31:0]         found_nonce,
    output logic                exhausted,
    output logic                timeout,
    output logic [31:0]         hashes_done
);

    ctrl_t       ctrl;
    logic [31:0] nonce_cur;
    logic [31:0] end_r;
    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expired;

    assign wd_clear  = (ctrl.state == ISSUE);
    assign wd_enable = (ctrl.state == WAIT);

    sweep_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
        .WD_W            (WD_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl        <= enter(IDLE);
            nonce_cur   <= '0;
            end_r       <= '0;
            found_nonce <= '0;
            hashes_done <= '0;
        end else if (abort) begin
            ctrl <= enter(IDLE);
        end else begin
            case (ctrl.state)
                IDLE, FOUND, EXHAUST, TMO: begin
                    if (start) begin
                        ctrl        <= enter(ISSUE);
                        nonce_cur   <= nonce_base;
                        end_r       <= nonce_end;
                        hashes_done <= '0;
                    end else if (ack && ctrl.state != IDLE) begin
                        ctrl <= enter(IDLE);
                    end
                end

                ISSUE: ctrl <= enter(WAIT);

                WAIT: begin
                    // A reply on the expiry cycle still counts; the watchdog only wins on silence.
                    if (hash.hash_done) begin
                        if (hashes_done != 32'hFFFF_FFFF) begin
                            hashes_done <= hashes_done + 32'd1;
                        end
                        if (hash.hash_hit) begin
                            found_nonce <= nonce_cur;
                            ctrl        <= enter(FOUND);
                        end else if (nonce_cur == end_r) begin
                            ctrl <= enter(EXHAUST);
                        end else begin
                            nonce_cur <= nonce_cur + 32'd1;
                            ctrl      <= enter(ISSUE);
                        end
                    end else if (wd_expired) begin
                        ctrl <= enter(TMO);
                    end
                end

                default: ctrl <= enter(IDLE);
            endcase
        end
    end

    assign hash.hash_start = ctrl.hash_start;
    assign hash.hash_nonce = nonce_cur;
    assign busy            = ctrl.busy;
    assign found           = ctrl.found;
    assign exhausted       = ctrl.exhausted;
    assign timeout         = ctrl.timeout;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Self-checking bench for nonce_sweep_ctrl: a behavioural hash core answers each
// hash_start, and every sweep is compared with a range model built from plain arithmetic.
module tb_nonce_sweep_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ack   = 1'b0;
    logic [31:0] nonce_base = '0;
    logic [31:0] nonce_end  = '0;
    logic        busy, found, exhausted, timeout;
    logic [31:0] found_nonce, hashes_done;

    logic core_done = 1'b0;
    logic core_hit  = 1'b0;
    logic man_done  = 1'b0;
    logic man_hit   = 1'b0;

    int runs  = 0;
    int fails = 0;

    nonce_sweep_ctrl_if bus ();
    assign bus.hash_done = core_done | man_done;
    assign bus.hash_hit  = core_hit | man_hit;

    nonce_sweep_ctrl #(
        .WATCHDOG_CYCLES (16),
        .WD_W            (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .ack         (ack),
        .nonce_base  (nonce_base),
        .nonce_end   (nonce_end),
        .hash        (bus),
        .busy        (busy),
        .found       (found),
        .found_nonce (found_nonce),
        .exhausted   (exhausted),
        .timeout     (timeout),
        .hashes_done (hashes_done)
    );

    always #5 clock = ~clock;

    // Record every nonce launched at the hash core.
    logic [31:0] issued[$];
    always @(negedge clock) begin
        if (bus.hash_start === 1'b1) issued.push_back(bus.hash_nonce);
    end

    // Behavioural hash core: replies core_delay cycles after each launch.
    bit          core_on = 1'b0;
    int          core_delay = 5;
    bit          hit_en = 1'b0;
    logic [31:0] hit_nonce = '0;
    int          cd_cnt = 0;
    logic [31:0] cd_nonce = '0;
    always @(negedge clock) begin
        core_done = 1'b0;
        core_hit  = 1'b0;
        if (!core_on) begin
            cd_cnt = 0;
        end else if (bus.hash_start === 1'b1) begin
            cd_cnt   = core_delay;
            cd_nonce = bus.hash_nonce;
        end else if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0) begin
                core_done = 1'b1;
                core_hit  = hit_en && (cd_nonce == hit_nonce);
            end
        end
    end

    // Reference: the ordered nonces a sweep must visit and whether it ends on a hit.
    logic [31:0] exp_q[$];
    bit          exp_hit;
    function automatic void model_sweep(input logic [31:0] b, input logic [31:0] e,
                                        input bit he, input logic [31:0] hn);
        logic [31:0] n;
        n = b;
        exp_q.delete();
        exp_hit = 1'b0;
        forever begin
            exp_q.push_back(n);
            if (he && n == hn) begin
                exp_hit = 1'b1;
                break;
            end
            if (n == e || exp_q.size() >= 4096) break;
            n = n + 32'd1;
        end
    endfunction

    function automatic bit same_seq();
        if (issued.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (issued[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] e);
        nonce_base = b;
        nonce_end  = e;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_terminal(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((found | exhausted | timeout) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic exec_sweep(input logic [31:0] b, input logic [31:0] e, input bit he,
                              input logic [31:0] hn, input int delay, output bit ok);
        model_sweep(b, e, he, hn);
        issued.delete();
        core_delay = delay;
        hit_en     = he;
        hit_nonce  = hn;
        core_on    = 1'b1;
        pulse_start(b, e);
        wait_terminal(exp_q.size() * (delay + 4) + 20, ok);
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        runs++;
        if ({bus.hash_start, busy, found, exhausted, timeout} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.hash_start, busy, found, exhausted, timeout});
        end
        runs++;
        if ({bus.hash_nonce, found_nonce, hashes_done} !== 96'b0) begin
            fails++;
            $display("FAIL reset_values: nonce %h found_nonce %h hashes %h expected all 0",
                     bus.hash_nonce, found_nonce, hashes_done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_exhaust();
        bit ok;
        exec_sweep(32'h10, 32'h13, 1'b0, '0, 5, ok);
        runs++;
        if (!ok || !same_seq()) begin
            fails++;
            $display("FAIL exhaust_nonces: done %0d issued %0d first %h expected %0d first %h",
                     ok, issued.size(), issued[0], exp_q.size(), exp_q[0]);
        end
        runs++;
        if ({found, exhausted, timeout, busy} !== 4'b0100) begin
            fails++;
            $display("FAIL exhaust_flags: got %b expected 0100", {found, exhausted, timeout, busy});
        end
        runs++;
        if (hashes_done !== 32'd4) begin
            fails++;
            $display("FAIL exhaust_count: got %0d expected 4", hashes_done);
        end
    endtask

    task automatic test_found();
        bit ok;
        exec_sweep(32'h42A1_4690, 32'h42A1_46A0, 1'b1, 32'h42A1_4695, 5, ok);
        tick(10);
        runs++;
        if (!ok || !same_seq()) begin
            fails++;
            $display("FAIL found_nonces: done %0d issued %0d expected %0d", ok, issued.size(), exp_q.size());
        end
        runs++;
        if ({found, exhausted, timeout, busy} !== 4'b1000) begin
            fails++;
            $display("FAIL found_flags: got %b expected 1000", {found, exhausted, timeout, busy});
        end
        runs++;
        if (found_nonce !== 32'h42A1_4695) begin
            fails++;
            $display("FAIL found_nonce: got %h expected 42a14695", found_nonce);
        end
        runs++;
        if (hashes_done !== 32'd6) begin
            fails++;
            $display("FAIL found_count: got %0d expected 6", hashes_done);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        exec_sweep(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, '0, 3, ok);
        runs++;
        if (!ok || !same_seq()) begin
            fails++;
            $display("FAIL wrap_nonces: done %0d issued %0d last %h expected %0d last %h",
                     ok, issued.size(), issued[issued.size()-1], exp_q.size(), exp_q[exp_q.size()-1]);
        end
        runs++;
        if ({exhausted, hashes_done} !== {1'b1, 32'd4}) begin
            fails++;
            $display("FAIL wrap_end: exhausted %b hashes %0d expected 1 and 4", exhausted, hashes_done);
        end
    endtask

    task automatic test_single();
        bit ok;
        exec_sweep(32'h77, 32'h77, 1'b0, '0, 2, ok);
        runs++;
        if (!ok || issued.size() != 1 || issued[0] !== 32'h77) begin
            fails++;
            $display("FAIL single_issue: done %0d issued %0d first %h expected 1 x 00000077",
                     ok, issued.size(), issued[0]);
        end
        runs++;
        if ({exhausted, hashes_done} !== {1'b1, 32'd1}) begin
            fails++;
            $display("FAIL single_end: exhausted %b hashes %0d expected 1 and 1", exhausted, hashes_done);
        end
    endtask

    task automatic test_ack();
        bit ok;
        exec_sweep(32'h500, 32'h510, 1'b1, 32'h503, 2, ok);
        pulse_ack();
        runs++;
        if (!ok || {found, exhausted, timeout, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL ack_flags: done %0d got %b expected 0000", ok, {found, exhausted, timeout, busy});
        end
        runs++;
        if ({found_nonce, hashes_done} !== {32'h503, 32'd4}) begin
            fails++;
            $display("FAIL ack_retain: found_nonce %h hashes %0d expected 00000503 and 4",
                     found_nonce, hashes_done);
        end
    endtask

    task automatic test_timeout();
        core_on = 1'b0;
        issued.delete();
        pulse_start(32'h1234, 32'h1240);
        tick(16);
        runs++;
        if ({found, exhausted, timeout, busy} !== 4'b0001) begin
            fails++;
            $display("FAIL tmo_before: got %b expected 0001", {found, exhausted, timeout, busy});
        end
        tick();
        runs++;
        if ({found, exhausted, timeout, busy} !== 4'b0010) begin
            fails++;
            $display("FAIL tmo_expiry: got %b expected 0010", {found, exhausted, timeout, busy});
        end
        runs++;
        if (issued.size() != 1 || hashes_done !== 32'd0) begin
            fails++;
            $display("FAIL tmo_activity: issued %0d hashes %0d expected 1 and 0", issued.size(), hashes_done);
        end
        pulse_ack();
        runs++;
        if ({found, exhausted, timeout, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL tmo_ack: got %b expected 0000", {found, exhausted, timeout, busy});
        end
    endtask

    task automatic test_wd_precedence();
        core_on = 1'b0;
        pulse_start(32'hABC, 32'hAC0);
        tick(16);
        man_done = 1'b1;
        man_hit  = 1'b1;
        tick();
        man_done = 1'b0;
        man_hit  = 1'b0;
        runs++;
        if ({found, exhausted, timeout, busy} !== 4'b1000) begin
            fails++;
            $display("FAIL wd_prec_flags: got %b expected 1000", {found, exhausted, timeout, busy});
        end
        runs++;
        if ({found_nonce, hashes_done} !== {32'hABC, 32'd1}) begin
            fails++;
            $display("FAIL wd_prec_values: found_nonce %h hashes %0d expected 00000abc and 1",
                     found_nonce, hashes_done);
        end
        pulse_ack();
    endtask

    task automatic test_abort();
        core_on = 1'b0;
        issued.delete();
        pulse_start(32'h200, 32'h210);
        tick(3);
        abort    = 1'b1;
        man_done = 1'b1;
        man_hit  = 1'b1;
        tick();
        abort    = 1'b0;
        man_done = 1'b0;
        man_hit  = 1'b0;
        runs++;
        if ({bus.hash_start, found, exhausted, timeout, busy} !== 5'b0 || hashes_done !== 32'd0) begin
            fails++;
            $display("FAIL abort_state: flags %b hashes %0d expected 00000 and 0",
                     {bus.hash_start, found, exhausted, timeout, busy}, hashes_done);
        end
        tick(10);
        runs++;
        if (issued.size() != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: issued %0d busy %b expected 1 and 0", issued.size(), busy);
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        model_sweep(32'h100, 32'h102, 1'b0, '0);
        issued.delete();
        core_delay = 4;
        hit_en     = 1'b0;
        core_on    = 1'b1;
        pulse_start(32'h100, 32'h102);
        tick(2);
        pulse_start(32'h900, 32'h905);
        tick();
        pulse_ack();
        wait_terminal(60, ok);
        tick(4);
        runs++;
        if (!ok || !same_seq()) begin
            fails++;
            $display("FAIL busy_nonces: done %0d issued %0d first %h expected %0d first %h",
                     ok, issued.size(), issued[0], exp_q.size(), exp_q[0]);
        end
        runs++;
        if ({exhausted, hashes_done} !== {1'b1, 32'd3}) begin
            fails++;
            $display("FAIL busy_end: exhausted %b hashes %0d expected 1 and 3", exhausted, hashes_done);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        model_sweep(32'h30, 32'h31, 1'b1, 32'h31);
        issued.delete();
        core_delay = 3;
        hit_en     = 1'b1;
        hit_nonce  = 32'h31;
        core_on    = 1'b1;
        ack = 1'b1;
        pulse_start(32'h30, 32'h31);
        ack = 1'b0;
        runs++;
        if ({found, exhausted, timeout, busy} !== 4'b0001) begin
            fails++;
            $display("FAIL b2b_start_ack: got %b expected 0001", {found, exhausted, timeout, busy});
        end
        wait_terminal(40, ok);
        tick(4);
        runs++;
        if (!ok || !same_seq() || found_nonce !== 32'h31 || hashes_done !== 32'd2) begin
            fails++;
            $display("FAIL b2b_first: done %0d issued %0d found_nonce %h hashes %0d expected 2, 00000031, 2",
                     ok, issued.size(), found_nonce, hashes_done);
        end
        exec_sweep(32'h40, 32'h42, 1'b0, '0, 2, ok);
        runs++;
        if (!ok || !same_seq() || {found, exhausted} !== 2'b01 || hashes_done !== 32'd3) begin
            fails++;
            $display("FAIL b2b_second: done %0d issued %0d flags %b hashes %0d expected 3, 01, 3",
                     ok, issued.size(), {found, exhausted}, hashes_done);
        end
    endtask

    task automatic test_random();
        bit          ok;
        logic [31:0] base, last, hn;
        int          len, idx, delay;
        bit          he;
        for (int it = 0; it < 12; it++) begin
            base  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 6))) : $urandom();
            len   = $urandom_range(0, 12);
            last  = base + 32'(len);
            he    = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, len + 3);
            hn    = base + 32'(idx);
            delay = $urandom_range(1, 10);
            exec_sweep(base, last, he, hn, delay, ok);
            runs++;
            if (!ok || !same_seq()) begin
                fails++;
                $display("FAIL rand_nonces[%0d]: done %0d issued %0d expected %0d base %h",
                         it, ok, issued.size(), exp_q.size(), base);
            end
            runs++;
            if ({found, exhausted, timeout} !== {exp_hit, !exp_hit, 1'b0} ||
                hashes_done !== 32'(exp_q.size()) ||
                (exp_hit && found_nonce !== exp_q[exp_q.size()-1])) begin
                fails++;
                $display("FAIL rand_result[%0d]: flags %b hashes %0d found_nonce %h expected hit %0d count %0d",
                         it, {found, exhausted, timeout}, hashes_done, found_nonce, exp_hit, exp_q.size());
            end
            if ($urandom_range(0, 1) == 1) pulse_ack();
        end
    endtask

    task automatic test_reset_mid();
        core_on = 1'b0;
        issued.delete();
        pulse_start(32'h5, 32'h9);
        tick(3);
        reset = 1'b1;
        tick();
        runs++;
        if ({bus.hash_start, busy, found, exhausted, timeout} !== 5'b0 ||
            {bus.hash_nonce, found_nonce, hashes_done} !== 96'b0) begin
            fails++;
            $display("FAIL midreset_outputs: flags %b nonce %h found_nonce %h hashes %0d expected all 0",
                     {bus.hash_start, busy, found, exhausted, timeout}, bus.hash_nonce, found_nonce, hashes_done);
        end
        reset = 1'b0;
        tick(20);
        runs++;
        if (issued.size() != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_quiet: issued %0d busy %b expected 1 and 0", issued.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_exhaust();
        test_found();
        test_wrap();
        test_single();
        test_ack();
        test_timeout();
        test_wd_precedence();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running after 2000000 time units");
        $fatal(1, "bench time limit reached");
    end

endmodule
